// File: rtl/spi_fifo_subperipheral.sv
// Byte FIFO drained by an SPI host through address-decoded strobes and filled by fabric pushes.
// The host reads a status byte, performs burst reads that pop one byte per SPI byte, or flushes the FIFO.
module spi_fifo_subperipheral #(
  parameter int         DEPTH          = 16,
  parameter logic [7:0] ADDRESS_STATUS = 8'h20,
  parameter logic [7:0] ADDRESS_READ   = 8'h21,
  parameter logic [7:0] ADDRESS_FLUSH  = 8'h22
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] address_in,
  input  logic       address_in_valid,
  input  logic       data_in_valid,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic [7:0] write_data,
  input  logic       write_valid,
  output logic       write_ready
);

  localparam int         PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [5:0] DEPTH_CNT = 6'(DEPTH);

  typedef enum logic [1:0] {IDLE, STATUS, READ, IGNORE} state_t;

  state_t          state;
  logic [7:0]      mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   rd_next;
  logic [5:0]      count;
  logic            underflow;
  logic            head_valid;   // presented byte is a real FIFO entry, not a 0x00 filler byte
  logic            addr_last;
  logic            data_last;

  logic            addr_rise;
  logic            addr_fall;
  logic            byte_done;
  logic            full;
  logic            empty;
  logic            flush;
  logic            push;
  logic            read_bd;
  logic            pop;
  logic [7:0]      status_byte;

  always_comb begin
    addr_rise   = address_in_valid & ~addr_last;
    addr_fall   = ~address_in_valid & addr_last;
    byte_done   = data_in_valid & ~data_last;
    full        = (count == DEPTH_CNT);
    empty       = (count == 6'd0);
    flush       = (state == IDLE) && addr_rise && (address_in == ADDRESS_FLUSH);
    push        = write_valid && !full && !flush;
    read_bd     = (state == READ) && byte_done && !addr_fall;
    pop         = read_bd && head_valid;
    rd_next     = rd_ptr + PW'(1);
    status_byte = {underflow, full, count};
  end

  assign write_ready = ~full;

  // NOTE: the storage array carries no reset; the pointers and count define which entries are live.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= write_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      underflow      <= 1'b0;
      head_valid     <= 1'b0;
      addr_last      <= 1'b0;
      data_last      <= 1'b0;
      data_out       <= 8'h00;
      data_out_valid <= 1'b0;
    end else begin
      addr_last      <= address_in_valid;
      data_last      <= data_in_valid;
      data_out_valid <= 1'b0;

      if (flush) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        underflow <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_next;
        if (push && !pop)      count <= count + 6'd1;
        else if (pop && !push) count <= count - 6'd1;
        // The host consumed a 0x00 filler byte that held no FIFO entry.
        if (read_bd && !head_valid) underflow <= 1'b1;
      end

      if (addr_fall) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (addr_rise) begin
              if (address_in == ADDRESS_STATUS) begin
                state          <= STATUS;
                data_out       <= status_byte;
                data_out_valid <= 1'b1;
              end else if (address_in == ADDRESS_READ) begin
                state          <= READ;
                data_out       <= empty ? 8'h00 : mem[rd_ptr];
                head_valid     <= !empty;
                data_out_valid <= 1'b1;
              end else begin
                state <= IGNORE;
              end
            end
          end
          STATUS: begin
            if (byte_done) begin
              data_out       <= status_byte;
              data_out_valid <= 1'b1;
            end
          end
          READ: begin
            if (byte_done) begin
              data_out_valid <= 1'b1;
              if (head_valid) begin
                // Popping the last entry always presents a 0x00 filler byte, even with a concurrent push.
                if (count == 6'd1) begin
                  data_out   <= 8'h00;
                  head_valid <= 1'b0;
                end else begin
                  data_out <= mem[rd_next];
                end
              end else if (!empty) begin
                data_out   <= mem[rd_ptr];
                head_valid <= 1'b1;
              end else begin
                data_out <= 8'h00;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
